// File: rtl/vga_value_scheduler.sv
// ============================================================================
// Module   : vga_value_scheduler
// Purpose  : Debounces the board switches and commits the displayed 4-bit value
//            only at vertical-sync start; optional auto-step mode for demos.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_value_scheduler #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int FRAMES_PER_STEP = 60,
  parameter bit VS_ACTIVE_LOW   = 1'b1
) (
  input  logic       clk_fpga,
  input  logic       reset,
  input  logic [3:0] sw_value,
  input  logic       auto_mode,
  input  logic       vga_vs,
  output logic [3:0] value,
  output logic       frame_tick,
  output logic       pending
);

  localparam int c_DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int c_FR_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [c_DB_W-1:0] c_DB_MAX = c_DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_FR_W-1:0] c_FR_MAX = c_FR_W'(FRAMES_PER_STEP - 1);
  localparam logic c_VS_IDLE = VS_ACTIVE_LOW;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  logic [3:0]        r_sw_s1, r_sw_s2;
  logic              r_auto_s1, r_auto_s2, r_auto_prev;
  logic              r_vs_s1, r_vs_s2, r_vs_s3;
  logic [3:0]        r_cand;
  logic [c_DB_W-1:0] r_cnt;
  logic [c_FR_W-1:0] r_fcnt;
  logic [3:0]        r_value;
  logic              r_frame_tick;
  logic              r_pending;
  state_t            r_state;

  logic w_vs_start;
  logic w_stable;

  // XOR with the idle level turns either polarity into "1 = asserted".
  assign w_vs_start = (r_vs_s2 ^ c_VS_IDLE) & ~(r_vs_s3 ^ c_VS_IDLE);
  assign w_stable   = (r_cnt == c_DB_MAX) && (r_sw_s2 == r_cand);

  always_ff @(posedge clk_fpga or negedge reset) begin
    if (!reset) begin
      r_sw_s1      <= '0;
      r_sw_s2      <= '0;
      r_auto_s1    <= 1'b0;
      r_auto_s2    <= 1'b0;
      r_auto_prev  <= 1'b0;
      r_vs_s1      <= c_VS_IDLE;
      r_vs_s2      <= c_VS_IDLE;
      r_vs_s3      <= c_VS_IDLE;
      r_cand       <= '0;
      r_cnt        <= '0;
      r_fcnt       <= '0;
      r_value      <= '0;
      r_frame_tick <= 1'b0;
      r_pending    <= 1'b0;
      r_state      <= ST_IDLE;
    end else begin
      r_sw_s1      <= sw_value;
      r_sw_s2      <= r_sw_s1;
      r_auto_s1    <= auto_mode;
      r_auto_s2    <= r_auto_s1;
      r_auto_prev  <= r_auto_s2;
      r_vs_s1      <= vga_vs;
      r_vs_s2      <= r_vs_s1;
      r_vs_s3      <= r_vs_s2;
      r_frame_tick <= w_vs_start;

      if (r_sw_s2 != r_cand) begin
        r_cand <= r_sw_s2;
        r_cnt  <= '0;
      end else if (r_cnt != c_DB_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (r_auto_s2 != r_auto_prev) begin
        r_fcnt    <= '0;
        r_state   <= ST_IDLE;
        r_pending <= 1'b0;
      end else if (r_auto_s2) begin
        r_state   <= ST_IDLE;
        r_pending <= 1'b0;
        if (r_frame_tick) begin
          if (r_fcnt == c_FR_MAX) begin
            r_value <= r_value + 4'd1;
            r_fcnt  <= '0;
          end else begin
            r_fcnt <= r_fcnt + 1'b1;
          end
        end
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_stable && (r_cand != r_value)) begin
              r_state   <= ST_PENDING;
              r_pending <= 1'b1;
            end
          end
          ST_PENDING: begin
            // A bouncing switch at frame start defers the commit to a later frame.
            if (r_frame_tick && w_stable) begin
              r_value   <= r_cand;
              r_state   <= ST_IDLE;
              r_pending <= 1'b0;
            end else if (w_stable && (r_cand == r_value)) begin
              r_state   <= ST_IDLE;
              r_pending <= 1'b0;
            end
          end
          default: begin
            r_state   <= ST_IDLE;
            r_pending <= 1'b0;
          end
        endcase
      end
    end
  end

  assign value      = r_value;
  assign frame_tick = r_frame_tick;
  assign pending    = r_pending;

endmodule

`default_nettype wire

// File: tb/tb_vga_value_scheduler.sv
// ============================================================================
// Module   : tb_vga_value_scheduler
// Purpose  : Scoreboard bench for vga_value_scheduler with directed scenarios.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_value_scheduler;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] sw;
  logic       auto_sw;
  logic       vs;
  logic [3:0] value;
  logic       frame_tick;
  logic       pending;

  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  int         fall_cyc = -1000;
  bit         gen_go = 1'b0;
  bit         mon_en = 1'b0;
  logic [3:0] exp_q[$];
  logic [3:0] prev_val;
  logic [3:0] exp_v;
  logic       exp_t;

  vga_value_scheduler #(
    .DEBOUNCE_CYCLES(4),
    .FRAMES_PER_STEP(3),
    .VS_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk_fpga  (clk),
    .reset     (reset_n),
    .sw_value  (sw),
    .auto_mode (auto_sw),
    .vga_vs    (vs),
    .value     (value),
    .frame_tick(frame_tick),
    .pending   (pending)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // 200-cycle frame, sync low for 10 cycles
  initial begin
    vs = 1'b1;
    wait (gen_go);
    forever begin
      repeat (190) @(negedge clk);
      vs = 1'b0;
      fall_cyc = cyc;
      repeat (10) @(negedge clk);
      vs = 1'b1;
    end
  end

  // Value monitor: every change of value must match the next queued commit.
  always @(negedge clk) begin
    if (mon_en && (value !== prev_val)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL value_unexpected: got %0d, expected no change", value);
      end else begin
        exp_v = exp_q.pop_front();
        check("value_seq", value, exp_v);
      end
      prev_val = value;
    end
  end

  // Tick monitor: pulse exactly one cycle, 3 cycles after the sync falling edge.
  always @(negedge clk) begin
    if (mon_en && reset_n) begin
      exp_t = (cyc == fall_cyc + 3);
      if (exp_t || frame_tick) check("frame_tick", frame_tick, exp_t);
    end
  end

  task automatic wait_tick();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_tick !== 1'b1 && n < 400);
    if (frame_tick !== 1'b1) begin
      n_checks++;
      n_errors++;
      $display("FAIL tick_timeout: got no frame_tick, expected one within 400 cycles");
    end
  endtask

  // Switch change at a negedge -> pending exactly 7 edges later.
  task automatic pend_latency(input string tag);
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      if (i == 6) check({tag, "_pending_early"}, pending, 0);
    end
    check({tag, "_pending_set"}, pending, 1);
  endtask

  initial begin
    reset_n = 1'b0;
    sw      = 4'd0;
    auto_sw = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_value", value, 0);
    check("rst_pending", pending, 0);
    check("rst_tick", frame_tick, 0);
    reset_n  = 1'b1;
    prev_val = value;
    mon_en   = 1'b1;
    gen_go   = 1'b1;

    // 1: idle frames
    wait_tick();
    wait_tick();
    check("t1_value", value, 0);
    check("t1_pending", pending, 0);

    // 2: mid-frame change waits for the frame
    repeat (50) @(negedge clk);
    sw = 4'd5;
    exp_q.push_back(4'd5);
    pend_latency("t2");
    check("t2_value_hold", value, 0);
    wait_tick();
    check("t2_value_at_tick", value, 0);
    check("t2_pending_at_tick", pending, 1);
    @(negedge clk);
    check("t2_value_commit", value, 5);
    check("t2_pending_clear", pending, 0);

    // 3: bounce never reaches pending
    wait_tick();
    repeat (10) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      sw = (i % 2 == 1) ? 4'd6 : 4'd5;
      repeat (2) begin
        @(negedge clk);
        check("t3_pending_bounce", pending, 0);
      end
    end
    exp_q.push_back(4'd6);
    wait_tick();
    @(negedge clk);
    check("t3_value", value, 6);

    // 4: auto mode from 14
    repeat (20) @(negedge clk);
    sw = 4'd14;
    exp_q.push_back(4'd14);
    wait_tick();
    @(negedge clk);
    check("t4_value_14", value, 14);
    repeat (20) @(negedge clk);
    auto_sw = 1'b1;
    exp_q.push_back(4'd15);
    exp_q.push_back(4'd0);
    for (int i = 1; i <= 6; i++) begin
      wait_tick();
      check("t4_pending_tick", pending, 0);
      @(negedge clk);
      check("t4_value_step", value, (14 + i / 3) % 16);
      check("t4_pending", pending, 0);
    end
    sw = 4'd0;
    repeat (20) @(negedge clk);
    auto_sw = 1'b0;
    repeat (20) @(negedge clk);
    check("t4_manual_value", value, 0);
    check("t4_manual_pending", pending, 0);

    // 5: reset while pending
    wait_tick();
    repeat (20) @(negedge clk);
    sw = 4'd9;
    pend_latency("t5a");
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("t5_rst_value", value, 0);
    check("t5_rst_pending", pending, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    pend_latency("t5b");
    check("t5_value_hold", value, 0);
    exp_q.push_back(4'd9);
    wait_tick();
    @(negedge clk);
    check("t5_value_commit", value, 9);

    // 6: stable coincides with frame_tick
    begin
      int target;
      target = fall_cyc + 197;
      while (cyc < target) @(negedge clk);
    end
    sw = 4'd3;
    exp_q.push_back(4'd3);
    wait_tick();
    check("t6_pending_at_tick", pending, 0);
    @(negedge clk);
    check("t6_value_no_commit", value, 9);
    check("t6_pending_set", pending, 1);
    wait_tick();
    @(negedge clk);
    check("t6_value_commit", value, 3);
    check("t6_pending_clear", pending, 0);

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
